// File: rtl/alu_wb_stage.sv
// alu_wb_stage: execute/write-back stage that sits directly after the register file.
// Single-cycle ALU ops write back on the cycle after accept. Shifts run one bit per
// cycle under a two-state FSM (IDLE/SHIFT). The result drives the regfile write port.
// Optional build macro ALU_FLAGS_EN adds registered zero_flag/ovf_flag outputs.
module alu_wb_stage #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] rd,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WIDTH-1:0]  wdata,
  output logic              busy
`ifdef ALU_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              ovf_flag
`endif
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    sh_q;
  logic [4:0]          cnt_q;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [WIDTH-1:0]    wdata_q;

  logic [WIDTH-1:0]    alu_d;
  logic [WIDTH-1:0]    sh_d;
  logic [4:0]          shamt;
  logic                is_shift;
  logic                is_single;

  assign shamt     = b[4:0];
  assign is_shift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  // Zero-amount shifts complete in one cycle like ordinary ALU ops.
  assign is_single = (op <= OP_SLTU) || (is_shift && (shamt == 5'd0));

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == SHIFT);
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

  // Single-cycle result; a shift here only arises with shamt=0, so it passes a.
  always_comb begin
    alu_d = '0;
    case (op)
      OP_ADD:  alu_d = a + b;
      OP_SUB:  alu_d = a - b;
      OP_AND:  alu_d = a & b;
      OP_OR:   alu_d = a | b;
      OP_XOR:  alu_d = a ^ b;
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: alu_d = a;
      default: alu_d = '0;
    endcase
  end

  // One-bit step of the iterative shifter; SRA replicates the sign bit.
  always_comb begin
    sh_d = sh_q;
    case (op_q)
      OP_SLL:  sh_d = {sh_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_d = {1'b0, sh_q[WIDTH-1:1]};
      OP_SRA:  sh_d = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_d = sh_q;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic ovf_d;
  logic zero_q;
  logic ovf_q;

  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result flips.
  always_comb begin
    ovf_d = 1'b0;
    if (op == OP_ADD)
      ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (alu_d[WIDTH-1] != a[WIDTH-1]);
    else if (op == OP_SUB)
      ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (alu_d[WIDTH-1] != a[WIDTH-1]);
  end

  // Flags follow every write-back result, including ones suppressed for x0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid && is_single) begin
        zero_q <= (alu_d == '0);
        ovf_q  <= ovf_d;
      end
    end else if (cnt_q == 5'd1) begin
      zero_q <= (sh_d == '0);
      ovf_q  <= 1'b0;
    end
  end

  assign zero_flag = zero_q;
  assign ovf_flag  = ovf_q;
`endif

  // FSM plus registered write port; we is a one-cycle pulse per completed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_single) begin
              we_q    <= (rd != '0);
              waddr_q <= rd;
              wdata_q <= alu_d;
            end else if (is_shift) begin
              state_q <= SHIFT;
              sh_q    <= a;
              cnt_q   <= shamt;
              op_q    <= op;
              rd_q    <= rd;
            end
            // Reserved opcodes are consumed without any write.
          end
        end
        SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= IDLE;
            we_q    <= (rd_q != '0);
            waddr_q <= rd_q;
            wdata_q <= sh_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
